// File: rtl/cache_ctrl_if.sv
// CPU word port and main-memory block port of the cache controller.
// The slave modport is the controller's view; master is the CPU/memory side.
interface cache_ctrl_if;
    logic         cpu_req;
    logic         cpu_rw;
    logic [9:0]   cpu_addr;
    logic [31:0]  cpu_wdata;
    logic [31:0]  cpu_rdata;
    logic         cpu_ready;
    logic         mem_read_write;
    logic [9:0]   mem_address;
    logic [127:0] mem_writedata;
    logic [127:0] mem_readdata;

    modport slave (
        input  cpu_req, cpu_rw, cpu_addr, cpu_wdata, mem_readdata,
        output cpu_rdata, cpu_ready, mem_read_write, mem_address, mem_writedata
    );

    modport master (
        output cpu_req, cpu_rw, cpu_addr, cpu_wdata, mem_readdata,
        input  cpu_rdata, cpu_ready, mem_read_write, mem_address, mem_writedata
    );
endinterface

// File: rtl/cache_ctrl.sv
// Direct-mapped write-back/write-allocate cache controller with 128-bit lines,
// fixed-latency memory sequencing and wrapping hit/miss counters.
module cache_ctrl #(
    parameter int NUM_LINES = 4,
    parameter int MEM_LAT   = 2,
    parameter int CNT_W     = 16
) (
    input  logic             clock,
    input  logic             reset,
    cache_ctrl_if.slave      bus,
    output logic [CNT_W-1:0] hit_cnt,
    output logic [CNT_W-1:0] miss_cnt
);
    localparam int INDEX_W = $clog2(NUM_LINES);
    localparam int TAG_W   = 6 - INDEX_W;
    localparam int LAT_W   = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_COMPARE,
        S_WRITEBACK,
        S_ALLOCATE,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic                 r_rw;
    logic [9:0]           r_addr;
    logic [31:0]          r_wdata;
    logic                 r_first;
    logic [LAT_W-1:0]     r_lat;

    logic [NUM_LINES-1:0] r_valid;
    logic [NUM_LINES-1:0] r_dirty;
    logic [TAG_W-1:0]     r_tag  [NUM_LINES];
    logic [127:0]         r_line [NUM_LINES];

    logic [31:0]          r_cpu_rdata;
    logic                 r_cpu_ready;
    logic                 r_mem_rw;
    logic [9:0]           r_mem_addr;
    logic [127:0]         r_mem_wdata;
    logic [CNT_W-1:0]     r_hit_cnt;
    logic [CNT_W-1:0]     r_miss_cnt;

    logic [TAG_W-1:0]     w_req_tag;
    logic [INDEX_W-1:0]   w_idx;
    logic [1:0]           w_word;
    logic [127:0]         w_line;
    logic [127:0]         w_line_wr;
    logic [31:0]          w_words [4];
    logic                 w_hit;
    logic                 w_victim_dirty;
    logic                 w_lat_last;
    logic                 w_unused;

    assign w_req_tag      = r_addr[9 -: TAG_W];
    assign w_idx          = r_addr[4 +: INDEX_W];
    assign w_word         = r_addr[3:2];
    assign w_line         = r_line[w_idx];
    assign w_hit          = r_valid[w_idx] && (r_tag[w_idx] == w_req_tag);
    assign w_victim_dirty = r_valid[w_idx] && r_dirty[w_idx];
    assign w_lat_last     = (r_lat == LAT_W'(MEM_LAT - 1));
    assign w_unused       = ^bus.cpu_addr[1:0];

    // Word lanes of the addressed line, and the same line with the write word merged in.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_word
            assign w_words[gi]            = w_line[32*gi +: 32];
            assign w_line_wr[32*gi +: 32] = (w_word == 2'(gi)) ? r_wdata : w_line[32*gi +: 32];
        end
    endgenerate

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:      if (bus.cpu_req) w_state_next = S_COMPARE;
            S_COMPARE: begin
                if (w_hit)               w_state_next = S_DONE;
                else if (w_victim_dirty) w_state_next = S_WRITEBACK;
                else                     w_state_next = S_ALLOCATE;
            end
            S_WRITEBACK: if (w_lat_last) w_state_next = S_ALLOCATE;
            S_ALLOCATE:  if (w_lat_last) w_state_next = S_COMPARE;
            S_DONE:      w_state_next = S_IDLE;
            default:     w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_rw        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_first     <= 1'b0;
            r_lat       <= '0;
            r_valid     <= '0;
            r_dirty     <= '0;
            r_cpu_rdata <= '0;
            r_cpu_ready <= 1'b0;
            r_mem_rw    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_hit_cnt   <= '0;
            r_miss_cnt  <= '0;
        end else begin
            r_state     <= w_state_next;
            r_cpu_ready <= (w_state_next == S_DONE);
            // Memory writes whenever this is high, so it tracks WRITEBACK exactly.
            r_mem_rw    <= (w_state_next == S_WRITEBACK);

            if ((r_state != w_state_next) ||
                ((r_state != S_WRITEBACK) && (r_state != S_ALLOCATE)))
                r_lat <= '0;
            else
                r_lat <= r_lat + LAT_W'(1);

            case (r_state)
                S_IDLE: begin
                    if (bus.cpu_req) begin
                        r_rw    <= bus.cpu_rw;
                        r_addr  <= bus.cpu_addr;
                        r_wdata <= bus.cpu_wdata;
                        r_first <= 1'b1;
                    end
                end
                S_COMPARE: begin
                    // Only the first compare of a request is counted; the post-refill one is not.
                    if (r_first) begin
                        r_first <= 1'b0;
                        if (w_hit) r_hit_cnt  <= r_hit_cnt + CNT_W'(1);
                        else       r_miss_cnt <= r_miss_cnt + CNT_W'(1);
                    end
                    if (w_hit) begin
                        if (r_rw) begin
                            r_line[w_idx]  <= w_line_wr;
                            r_dirty[w_idx] <= 1'b1;
                        end else begin
                            r_cpu_rdata <= w_words[w_word];
                        end
                    end else if (w_victim_dirty) begin
                        r_mem_addr  <= {r_tag[w_idx], w_idx, 4'b0000};
                        r_mem_wdata <= w_line;
                    end else begin
                        r_mem_addr <= {w_req_tag, w_idx, 4'b0000};
                    end
                end
                S_WRITEBACK: begin
                    if (w_lat_last) begin
                        r_dirty[w_idx] <= 1'b0;
                        r_mem_addr     <= {w_req_tag, w_idx, 4'b0000};
                    end
                end
                S_ALLOCATE: begin
                    if (w_lat_last) begin
                        r_line[w_idx]  <= bus.mem_readdata;
                        r_tag[w_idx]   <= w_req_tag;
                        r_valid[w_idx] <= 1'b1;
                        r_dirty[w_idx] <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.cpu_rdata      = r_cpu_rdata;
    assign bus.cpu_ready      = r_cpu_ready;
    assign bus.mem_read_write = r_mem_rw;
    assign bus.mem_address    = r_mem_addr;
    assign bus.mem_writedata  = r_mem_wdata;
    assign hit_cnt            = r_hit_cnt;
    assign miss_cnt           = r_miss_cnt;
endmodule

// File: tb/tb_cache_ctrl.sv
// Bench for cache_ctrl: directed scenarios plus random traffic against a
// line-level cache/memory model; memory is modelled as a combinational array.
module tb_cache_ctrl;
    localparam int NUM_LINES = 4;
    localparam int MEM_LAT   = 2;
    localparam int CNT_W     = 10;
    localparam int IDX_W     = 2;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic [CNT_W-1:0] hit_cnt;
    logic [CNT_W-1:0] miss_cnt;

    cache_ctrl_if bus();

    cache_ctrl #(
        .NUM_LINES(NUM_LINES),
        .MEM_LAT  (MEM_LAT),
        .CNT_W    (CNT_W)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .bus     (bus),
        .hit_cnt (hit_cnt),
        .miss_cnt(miss_cnt)
    );

    always #5 clock = ~clock;

    logic [127:0] phys_mem [64] = '{default: '0};
    assign bus.mem_readdata = phys_mem[bus.mem_address[9:4]];
    always @(posedge clock) begin
        if (bus.mem_read_write) phys_mem[bus.mem_address[9:4]] <= bus.mem_writedata;
    end

    // Reference: what the cache holds and what memory holds, per line/block.
    logic [127:0] ref_mem  [64];
    logic [127:0] ref_line [NUM_LINES];
    int           ref_tag  [NUM_LINES];
    bit           ref_valid[NUM_LINES];
    bit           ref_dirty[NUM_LINES];
    int           ref_hit;
    int           ref_miss;

    int           n_checks = 0;
    int           n_errors = 0;
    logic [31:0]  last_rdata;
    logic [127:0] last_wb_data;

    task automatic check_eq(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NUM_LINES; i++) begin
            ref_valid[i] = 1'b0;
            ref_dirty[i] = 1'b0;
        end
        ref_hit  = 0;
        ref_miss = 0;
    endtask

    task automatic go_idle(input int n);
        bus.cpu_req = 1'b0;
        repeat (n) @(negedge clock);
    endtask

    // Call at a negedge where the DUT is IDLE; returns at the IDLE negedge after DONE.
    task automatic do_req(input logic rw, input logic [9:0] addr, input logic [31:0] wdata);
        int          idx, tag, word, blk_new, blk_old, lat, cyc, bad_rw;
        bit          hit, wb, exp_rw, got_ready;
        logic [127:0] victim;
        logic [31:0]  exp_rdata;

        idx     = (int'(addr) >> 4) % NUM_LINES;
        tag     = int'(addr) >> (4 + IDX_W);
        word    = (int'(addr) >> 2) % 4;
        blk_new = int'(addr) >> 4;
        hit     = ref_valid[idx] && (ref_tag[idx] == tag);
        wb      = !hit && ref_valid[idx] && ref_dirty[idx];
        blk_old = ref_tag[idx] * NUM_LINES + idx;
        victim  = ref_line[idx];
        exp_rdata = '0;

        if (hit) ref_hit  = (ref_hit + 1) % (1 << CNT_W);
        else     ref_miss = (ref_miss + 1) % (1 << CNT_W);
        if (!hit) begin
            if (wb) ref_mem[blk_old] = victim;
            ref_line[idx]  = ref_mem[blk_new];
            ref_tag[idx]   = tag;
            ref_valid[idx] = 1'b1;
            ref_dirty[idx] = 1'b0;
        end
        if (rw) begin
            ref_line[idx][word*32 +: 32] = wdata;
            ref_dirty[idx] = 1'b1;
        end else begin
            exp_rdata = ref_line[idx][word*32 +: 32];
        end
        lat = hit ? 2 : (wb ? 3 + 2*MEM_LAT : 3 + MEM_LAT);

        bus.cpu_req   = 1'b1;
        bus.cpu_rw    = rw;
        bus.cpu_addr  = addr;
        bus.cpu_wdata = wdata;

        cyc = 0;
        bad_rw = 0;
        got_ready = 1'b0;
        while (!got_ready && cyc < 40) begin
            @(negedge clock);
            cyc++;
            exp_rw = wb && (cyc >= 2) && (cyc < 2 + MEM_LAT);
            if (bus.mem_read_write !== exp_rw) bad_rw++;
            if (exp_rw) begin
                check_eq("wb_addr", bus.mem_address, 128'(blk_old * 16));
                check_eq("wb_data", bus.mem_writedata, victim);
                last_wb_data = bus.mem_writedata;
            end
            if (!hit && (cyc == 2 + (wb ? MEM_LAT : 0) || cyc == 1 + (wb ? 2 : 1) * MEM_LAT))
                check_eq("alloc_addr", bus.mem_address, 128'(blk_new * 16));
            if (bus.cpu_ready === 1'b1) got_ready = 1'b1;
        end
        check_eq("latency", 128'(cyc), 128'(lat));
        check_eq("mem_rw_cycles", 128'(bad_rw), 128'(0));
        if (!rw) check_eq("rdata", bus.cpu_rdata, exp_rdata);
        check_eq("hit_cnt", hit_cnt, 128'(ref_hit));
        check_eq("miss_cnt", miss_cnt, 128'(ref_miss));
        last_rdata = bus.cpu_rdata;
        $display("req %s addr=%03h wdata=%08h hit=%0d lat=%0d rdata=%08h hits=%0d misses=%0d",
                 rw ? "WR" : "RD", addr, wdata, hit, cyc, bus.cpu_rdata, hit_cnt, miss_cnt);
        @(negedge clock);
        check_eq("ready_pulse", bus.cpu_ready, 1'b0);
    endtask

    initial begin
        int bad;
        logic [9:0] a;

        bus.cpu_req   = 1'b0;
        bus.cpu_rw    = 1'b0;
        bus.cpu_addr  = '0;
        bus.cpu_wdata = '0;
        for (int i = 0; i < 64; i++) ref_mem[i] = '0;
        for (int i = 0; i < NUM_LINES; i++) begin
            ref_line[i] = '0;
            ref_tag[i]  = 0;
        end
        model_reset();
        last_rdata   = '0;
        last_wb_data = '0;

        reset = 1'b1;
        repeat (2) @(negedge clock);
        check_eq("rst_ready", bus.cpu_ready, 1'b0);
        check_eq("rst_rdata", bus.cpu_rdata, 32'h0);
        check_eq("rst_mem_rw", bus.mem_read_write, 1'b0);
        check_eq("rst_mem_addr", bus.mem_address, 10'h0);
        check_eq("rst_mem_wdata", bus.mem_writedata, 128'h0);
        check_eq("rst_hit_cnt", hit_cnt, 0);
        check_eq("rst_miss_cnt", miss_cnt, 0);
        reset = 1'b0;

        // Cold miss, write hit, read hit, dirty eviction, refill of evicted data.
        do_req(1'b0, 10'h000, 32'h0);
        check_eq("tp1_miss", miss_cnt, 1);
        do_req(1'b1, 10'h004, 32'hDEADBEEF);
        do_req(1'b0, 10'h004, 32'h0);
        check_eq("tp2_rdata", last_rdata, 32'hDEADBEEF);
        check_eq("tp2_hits", hit_cnt, 2);
        do_req(1'b0, 10'h044, 32'h0);
        check_eq("tp3_wb_word", last_wb_data[63:32], 32'hDEADBEEF);
        do_req(1'b0, 10'h004, 32'h0);
        check_eq("tp4_rdata", last_rdata, 32'hDEADBEEF);
        go_idle(1);

        // Reset during the second ALLOCATE cycle.
        bus.cpu_req  = 1'b1;
        bus.cpu_rw   = 1'b0;
        bus.cpu_addr = 10'h044;
        repeat (3) @(negedge clock);
        check_eq("abort_alloc_addr", bus.mem_address, 10'h040);
        reset = 1'b1;
        bus.cpu_req = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        model_reset();
        check_eq("abort_ready", bus.cpu_ready, 1'b0);
        check_eq("abort_mem_rw", bus.mem_read_write, 1'b0);
        check_eq("abort_hits", hit_cnt, 0);
        check_eq("abort_misses", miss_cnt, 0);
        do_req(1'b0, 10'h004, 32'h0);
        check_eq("post_abort_miss", miss_cnt, 1);

        // Back-to-back hits on a resident line until the hit counter wraps.
        for (int i = 0; i < (1 << CNT_W); i++) begin
            a = 10'h000 | 10'($urandom_range(0, 3) * 4);
            do_req(1'($urandom_range(0, 1)), a, $urandom);
        end
        check_eq("hit_wrap", hit_cnt, 0);
        check_eq("miss_hold", miss_cnt, 1);

        // Reset during the first WRITEBACK cycle: that cycle's write lands, nothing after.
        do_req(1'b1, 10'h008, 32'h12345678);
        bus.cpu_req  = 1'b1;
        bus.cpu_rw   = 1'b0;
        bus.cpu_addr = 10'h048;
        repeat (2) @(negedge clock);
        check_eq("abort_wb_rw", bus.mem_read_write, 1'b1);
        check_eq("abort_wb_data", bus.mem_writedata, ref_line[0]);
        ref_mem[0] = ref_line[0];
        reset = 1'b1;
        bus.cpu_req = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        model_reset();
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            if (bus.mem_read_write !== 1'b0) bad++;
            @(negedge clock);
        end
        check_eq("abort_wb_no_write", 128'(bad), 128'(0));
        do_req(1'b0, 10'h008, 32'h0);
        check_eq("abort_wb_rdata", last_rdata, 32'h12345678);
        go_idle(1);

        // Random mixed traffic over conflicting tags.
        for (int i = 0; i < 300; i++) begin
            a = {4'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'b00};
            do_req(1'($urandom_range(0, 1)), a, $urandom);
            if ($urandom_range(0, 2) == 0) go_idle($urandom_range(1, 3));
        end
        go_idle(2);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/cache_ctrl.md
Name: cache_ctrl

Overview:
- Direct-mapped, write-back, write-allocate cache controller between the CPU word interface and the 128-bit-block main memory.
- Main memory has a 10-bit byte address, 64 blocks of 16 bytes, and reads/writes combinationally whenever its inputs are driven.
- The controller holds the tag/valid/dirty/data arrays and sequences line refills and dirty-line write-backs.
- It drives the memory's read_write, address and writedata inputs and waits a fixed MEM_LAT cycles per access.

Parameters:
- NUM_LINES, 4, number of cache lines; power of two, 2..16. INDEX_W = log2(NUM_LINES); TAG_W = 6 - INDEX_W.
- MEM_LAT, 2, cycles each memory access is held before it completes; must be ≥1.

Ports:
- clock  in  1  single clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high
- cpu_req  in  1  request valid; held high with stable inputs until cpu_ready
- cpu_rw  in  1  0 = read, 1 = write
- cpu_addr  in  10  byte address; [9:4+INDEX_W] tag, [3+INDEX_W:4] index, [3:2] word, [1:0] ignored
- cpu_wdata  in  32  write word
- cpu_rdata  out  32  read word; valid while cpu_ready=1
- cpu_ready  out  1  one-cycle completion pulse
- mem_read_write  out  1  0 = read, 1 = write to main memory
- mem_address  out  10  block address; low 4 bits always 0
- mem_writedata  out  128  victim line during write-back
- mem_readdata  in  128  block returned by main memory
- hit_cnt  out  16  count of requests that hit on first compare; wraps
- miss_cnt  out  16  count of requests that missed; wraps

Behaviour:
- Reset (synchronous, active-high):
  - state = IDLE; all valid and dirty bits = 0.
  - cpu_ready = 0, cpu_rdata = 0, mem_read_write = 0, mem_address = 0, mem_writedata = 0.
  - hit_cnt = miss_cnt = 0. Data and tag arrays are not cleared.
- All outputs are registered.
- mem_read_write is 1 only in WRITEBACK, because main memory writes whenever it is 1.
- mem_writedata and mem_address are stable during every WRITEBACK cycle.
- IDLE: if cpu_req=1, latch rw/addr/wdata and go to COMPARE. Otherwise stay.
- COMPARE: hit = valid[idx] and tag[idx] == req_tag.
  - Hit, read: cpu_rdata <= selected word; go to DONE.
  - Hit, write: replace the selected 32-bit word, set dirty[idx] = 1, go to DONE.
  - Miss, clean or invalid line: go to ALLOCATE.
  - Miss, valid and dirty line: go to WRITEBACK.
  - hit_cnt or miss_cnt increments only on the first COMPARE of a request. The re-compare after a refill is not counted.
- WRITEBACK:
  - mem_read_write = 1, mem_address = {tag[idx], idx, 4'b0}, mem_writedata = line[idx].
  - Held exactly MEM_LAT cycles, then clear dirty[idx] and go to ALLOCATE.
- ALLOCATE:
  - mem_read_write = 0, mem_address = {req_tag, idx, 4'b0}.
  - Held MEM_LAT cycles. On the last cycle, capture mem_readdata into line[idx], set tag, valid = 1, dirty = 0.
  - Then return to COMPARE, which now hits.
- DONE: cpu_ready = 1 for exactly one cycle, then IDLE.
  - CPU drops cpu_req the cycle after ready.
  - If cpu_req is still high in IDLE, it is treated as a new request.
- Latency from the accept cycle (IDLE with cpu_req=1) to the cpu_ready cycle:
  - hit: 2 cycles
  - clean miss: 3 + MEM_LAT cycles
  - dirty miss: 3 + 2·MEM_LAT cycles
- Word select: word 0 = line[31:0], …, word 3 = line[127:96].
- Reset mid-WRITEBACK or mid-ALLOCATE aborts immediately: cache invalidated, dirty data lost, no further memory write.
- Counter wrap: 16'hFFFF + 1 = 16'h0000.

Test Plan (MEM_LAT=2, NUM_LINES=4, memory preloaded 0):
1. Reset, then read 0x000 -> miss_cnt=1. ALLOCATE drives mem_address=0x000, mem_read_write=0 for 2 cycles. cpu_ready 5 cycles after accept, cpu_rdata=0.
2. Write 0xDEADBEEF to 0x004 (same line, now valid) -> hit, ready after 2 cycles, hit_cnt=1. Then read 0x004 -> rdata=0xDEADBEEF in 2 cycles, hit_cnt=2.
3. Read 0x044 (tag 1, index 0, line dirty) -> WRITEBACK for exactly 2 cycles:
   - mem_read_write=1, mem_address=0x000, mem_writedata[63:32]=0xDEADBEEF.
   - Then ALLOCATE at 0x040; ready 7 cycles after accept.
4. Read 0x004 again -> miss, line refilled from memory, rdata=0xDEADBEEF (write-back verified). mem_read_write never 1 outside WRITEBACK.
5. Assert reset during the second ALLOCATE cycle -> next cycle state IDLE, cpu_ready=0, mem_read_write=0, counters 0. Read 0x004 then misses.
6. Issue 65536 hits to a resident line -> hit_cnt wraps to 0, miss_cnt unchanged. Back-to-back requests issued one cycle after each ready are all accepted.
